// File: rtl/plb_dac_user_logic.sv
// plb_dac_user_logic
//   PLB IPIF user-logic slave driving a 10-bit parallel DAC.
//   Two software registers: CTRL (CE 0) and DATA (CE 1).
//   CTRL: [0] EN, [1] FMT, [2] CLKMD, [3] PINMD, [16:31] DIV.
//   DATA: [0:9] DAC code.
//   Bit 0 is the MSB on every bus-side vector.
//   The DAC conversion clock is Bus2IP_Clk / (2*(DIV+1)).
//   A new code is loaded onto the pins on each conversion-clock falling edge,
//   so it is stable at the following rising edge.
//
// Ports
//   Bus2IP_Clk, Bus2IP_Reset   clock, synchronous active-high reset
//   Bus2IP_Data/BE/RdCE/WrCE   slave-attachment write data, byte enables, chip enables
//   IP2Bus_Data/RdAck/WrAck    read data and combinational acknowledges
//   IP2Bus_Error               tied to 0
//   IP2DAC_*                   DAC code, conversion clock and mode pins
//
// Configuration macro
//   DAC_FORMAT_CONV_EN  when defined and FMT=1, the code MSB is inverted on load
//                       (two's complement to offset binary), and IP2DAC_Format is 0.
module plb_dac_user_logic #(
  parameter int unsigned C_SLV_DWIDTH = 32,
  parameter int unsigned C_NUM_REG    = 2,
  parameter int unsigned C_DAC_DWIDTH = 10
) (
  input  logic                      Bus2IP_Clk,
  input  logic                      Bus2IP_Reset,
  input  logic [0:C_SLV_DWIDTH-1]   Bus2IP_Data,
  input  logic [0:C_SLV_DWIDTH/8-1] Bus2IP_BE,
  input  logic [0:C_NUM_REG-1]      Bus2IP_RdCE,
  input  logic [0:C_NUM_REG-1]      Bus2IP_WrCE,
  output logic [0:C_SLV_DWIDTH-1]   IP2Bus_Data,
  output logic                      IP2Bus_RdAck,
  output logic                      IP2Bus_WrAck,
  output logic                      IP2Bus_Error,
  output logic [0:C_DAC_DWIDTH-1]   IP2DAC_Data,
  output logic                      IP2DAC_DCLKIO,
  output logic                      IP2DAC_Clkout,
  output logic                      IP2DAC_PinMD,
  output logic                      IP2DAC_ClkMD,
  output logic                      IP2DAC_Format,
  output logic                      IP2DAC_PWRDN
);

  localparam int unsigned BE_W  = C_SLV_DWIDTH / 8;
  localparam int unsigned CNT_W = 16;

  logic [0:C_SLV_DWIDTH-1] ctrl_q, ctrl_d;
  logic [0:C_SLV_DWIDTH-1] data_q, data_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    dclk_q, dclk_d;
  logic [0:C_DAC_DWIDTH-1] dac_q, dac_d;

  logic                    wr_onehot, rd_onehot;
  logic                    ctrl_en, ctrl_fmt;
  logic [CNT_W-1:0]        div;
  logic [0:C_DAC_DWIDTH-1] code_raw, code_next;

  assign ctrl_en  = ctrl_q[0];
  assign ctrl_fmt = ctrl_q[1];
  assign div      = ctrl_q[C_SLV_DWIDTH-CNT_W +: CNT_W];
  assign code_raw = data_q[0:C_DAC_DWIDTH-1];

  // Multi-hot or zero CE selects nothing.
  assign wr_onehot = ($countones(Bus2IP_WrCE) == 1);
  assign rd_onehot = ($countones(Bus2IP_RdCE) == 1);

  // Code presented to the DAC on the next load.
  always_comb begin
    code_next = code_raw;
`ifdef DAC_FORMAT_CONV_EN
    if (ctrl_fmt) begin
      code_next = {~code_raw[0], code_raw[1:C_DAC_DWIDTH-1]};
    end
`endif
  end

  // Register writes, conversion-clock divider and code load.
  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    dclk_d = dclk_q;
    dac_d  = dac_q;

    if (wr_onehot) begin
      for (int i = 0; i < BE_W; i++) begin
        if (Bus2IP_BE[i]) begin
          if (Bus2IP_WrCE[0]) ctrl_d[8*i +: 8] = Bus2IP_Data[8*i +: 8];
          if (Bus2IP_WrCE[1]) data_d[8*i +: 8] = Bus2IP_Data[8*i +: 8];
        end
      end
    end

    if (!ctrl_en) begin
      cnt_d  = '0;
      dclk_d = 1'b0;
    end else if (cnt_q == div) begin
      cnt_d  = '0;
      dclk_d = ~dclk_q;
      // Load on the falling edge so the code settles before the next rise.
      if (dclk_q) dac_d = code_next;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      ctrl_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
      dclk_q <= 1'b0;
      dac_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      dclk_q <= dclk_d;
      dac_q  <= dac_d;
    end
  end

  // Read mux; unselected or multi-hot reads return 0.
  always_comb begin
    IP2Bus_Data = '0;
    if (rd_onehot) begin
      if (Bus2IP_RdCE[0])      IP2Bus_Data = ctrl_q;
      else if (Bus2IP_RdCE[1]) IP2Bus_Data = data_q;
    end
  end

  assign IP2Bus_RdAck  = |Bus2IP_RdCE;
  assign IP2Bus_WrAck  = |Bus2IP_WrCE;
  assign IP2Bus_Error  = 1'b0;

  assign IP2DAC_Data   = dac_q;
  assign IP2DAC_DCLKIO = dclk_q;
  assign IP2DAC_Clkout = dclk_q;
  assign IP2DAC_PinMD  = ctrl_q[3];
  assign IP2DAC_ClkMD  = ctrl_q[2];
`ifdef DAC_FORMAT_CONV_EN
  assign IP2DAC_Format = 1'b0;
`else
  assign IP2DAC_Format = ctrl_fmt;
`endif
  assign IP2DAC_PWRDN  = ~ctrl_en;

endmodule

// File: tb/tb_plb_dac_user_logic.sv
module tb_plb_dac_user_logic;

  logic        clk;
  logic        rst;
  logic [0:31] bus_data;
  logic [0:3]  be;
  logic [0:1]  rdce;
  logic [0:1]  wrce;
  logic [0:31] ip2bus_data;
  logic        rdack, wrack, err;
  logic [0:9]  dac_data;
  logic        dclk, clkout, pinmd, clkmd, fmt_o, pwrdn;

  int checks = 0;
  int errors = 0;

  plb_dac_user_logic dut (
    .Bus2IP_Clk    (clk),
    .Bus2IP_Reset  (rst),
    .Bus2IP_Data   (bus_data),
    .Bus2IP_BE     (be),
    .Bus2IP_RdCE   (rdce),
    .Bus2IP_WrCE   (wrce),
    .IP2Bus_Data   (ip2bus_data),
    .IP2Bus_RdAck  (rdack),
    .IP2Bus_WrAck  (wrack),
    .IP2Bus_Error  (err),
    .IP2DAC_Data   (dac_data),
    .IP2DAC_DCLKIO (dclk),
    .IP2DAC_Clkout (clkout),
    .IP2DAC_PinMD  (pinmd),
    .IP2DAC_ClkMD  (clkmd),
    .IP2DAC_Format (fmt_o),
    .IP2DAC_PWRDN  (pwrdn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wrce;
    logic [1:0]  rdce;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        wrack;
    logic        rdack;
    logic [31:0] rdata;
    logic        pinmd;
    logic        clkmd;
    logic        fmt;
    logic        pwrdn;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  function automatic logic exp_format(input logic f);
`ifdef DAC_FORMAT_CONV_EN
    return 1'b0;
`else
    return f;
`endif
  endfunction

  // One write cycle; WrAck checked while CE is held.
  task automatic bus_write(input logic [1:0] ce, input logic [3:0] b, input logic [31:0] d);
    wrce = ce; be = b; bus_data = d;
    #1;
    check("wrack", 32'(wrack), 32'(1));
    tick();
    wrce = 2'b00; be = 4'h0; bus_data = '0;
  endtask

  // Wait for the first DCLKIO fall after now; returns 1 if seen.
  task automatic wait_fall(output logic seen);
    logic prev;
    prev = dclk;
    seen = 1'b0;
    for (int n = 0; n < 64; n++) begin
      tick();
      if (prev && !dclk) begin
        seen = 1'b1;
        break;
      end
      prev = dclk;
    end
  endtask

  // Count clock edges until DCLKIO equals val (64 means timeout).
  task automatic count_until(input logic val, output int n);
    n = 0;
    while (n < 64) begin
      tick();
      n++;
      if (dclk == val) break;
    end
  endtask

  initial begin
    logic        seen;
    int          n_rise, n_hi, n_lo;
    logic [9:0]  codes[3];
    logic [9:0]  prev_code;

    rst = 1'b1; bus_data = '0; be = '0; rdce = '0; wrce = '0;

    //                 wrce   rdce   be       wdata         wa   ra   rdata        pin  clk  fmt  pwd
    vecs[0]  = '{2'b10, 2'b00, 4'b1111, 32'h7000_1234, 1'b1, 1'b0, 32'h0,        1'b1,1'b1,1'b1,1'b1};
    vecs[1]  = '{2'b00, 2'b10, 4'b0000, 32'h0,         1'b0, 1'b1, 32'h7000_1234,1'b1,1'b1,1'b1,1'b1};
    vecs[2]  = '{2'b01, 2'b00, 4'b0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0,        1'b1,1'b1,1'b1,1'b1};
    vecs[3]  = '{2'b00, 2'b01, 4'b0000, 32'h0,         1'b0, 1'b1, 32'h0000_00FF,1'b1,1'b1,1'b1,1'b1};
    vecs[4]  = '{2'b11, 2'b00, 4'b1111, 32'hAAAA_AAAA, 1'b1, 1'b0, 32'h0,        1'b1,1'b1,1'b1,1'b1};
    vecs[5]  = '{2'b00, 2'b01, 4'b0000, 32'h0,         1'b0, 1'b1, 32'h0000_00FF,1'b1,1'b1,1'b1,1'b1};
    vecs[6]  = '{2'b00, 2'b10, 4'b0000, 32'h0,         1'b0, 1'b1, 32'h7000_1234,1'b1,1'b1,1'b1,1'b1};
    vecs[7]  = '{2'b00, 2'b00, 4'b1111, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,        1'b1,1'b1,1'b1,1'b1};
    vecs[8]  = '{2'b00, 2'b11, 4'b0000, 32'h0,         1'b0, 1'b1, 32'h0,        1'b1,1'b1,1'b1,1'b1};
    vecs[9]  = '{2'b10, 2'b00, 4'b1000, 32'h5AFF_FFFF, 1'b1, 1'b0, 32'h0,        1'b1,1'b0,1'b1,1'b1};
    vecs[10] = '{2'b00, 2'b10, 4'b0000, 32'h0,         1'b0, 1'b1, 32'h5A00_1234,1'b1,1'b0,1'b1,1'b1};
    vecs[11] = '{2'b01, 2'b00, 4'b0110, 32'h1234_5678, 1'b1, 1'b0, 32'h0,        1'b1,1'b0,1'b1,1'b1};
    vecs[12] = '{2'b00, 2'b01, 4'b0000, 32'h0,         1'b0, 1'b1, 32'h0034_56FF,1'b1,1'b0,1'b1,1'b1};

    // Reset state
    repeat (5) tick();
    check("rst_pwrdn",  32'(pwrdn),    32'(1));
    check("rst_dclk",   32'(dclk),     32'(0));
    check("rst_clkout", 32'(clkout),   32'(0));
    check("rst_dac",    32'(dac_data), 32'(0));
    check("rst_rdack",  32'(rdack),    32'(0));
    check("rst_wrack",  32'(wrack),    32'(0));
    check("rst_modes",  32'({pinmd, clkmd, fmt_o}), 32'(0));
    check("rst_error",  32'(err),      32'(0));
    rst = 1'b0;

    // Register access table (EN kept 0)
    for (int i = 0; i < 13; i++) begin
      wrce = vecs[i].wrce; rdce = vecs[i].rdce; be = vecs[i].be; bus_data = vecs[i].wdata;
      #1;
      check($sformatf("v%0d_wrack", i), 32'(wrack), 32'(vecs[i].wrack));
      check($sformatf("v%0d_rdack", i), 32'(rdack), 32'(vecs[i].rdack));
      check($sformatf("v%0d_rdata", i), 32'(ip2bus_data), vecs[i].rdata);
      tick();
      wrce = '0; rdce = '0; be = '0; bus_data = '0;
      check($sformatf("v%0d_modes", i), 32'({pinmd, clkmd, fmt_o, pwrdn}),
            32'({vecs[i].pinmd, vecs[i].clkmd, exp_format(vecs[i].fmt), vecs[i].pwrdn}));
      check($sformatf("v%0d_idle", i), 32'({dclk, dac_data}), 32'(0));
    end

    // EN with DIV=0: DCLKIO toggles every clock
    do_reset(2);
    bus_write(2'b10, 4'b1111, 32'h8000_0000);
    check("en_pwrdn",  32'(pwrdn),  32'(0));
    check("en_format", 32'(fmt_o),  32'(0));
    check("en_dclk0",  32'(dclk),   32'(0));
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("div0_dclk%0d", k), 32'(dclk), 32'(k % 2));
      check($sformatf("div0_clkout%0d", k), 32'(clkout), 32'(k % 2));
    end

    // Codes follow at each DCLKIO fall
    codes[0] = 10'h00F; codes[1] = 10'h0FF; codes[2] = 10'h3FF;
    prev_code = 10'h000;
    for (int c = 0; c < 3; c++) begin
      bus_write(2'b01, 4'b1111, {codes[c], 22'h0});
      check($sformatf("code%0d_hold", c), 32'(dac_data), 32'(prev_code));
      wait_fall(seen);
      check($sformatf("code%0d_fall_seen", c), 32'(seen), 32'(1));
      check($sformatf("code%0d_dac", c), 32'(dac_data), 32'(codes[c]));
      prev_code = codes[c];
    end

    // CTRL=0: power down, clock stopped, code held
    bus_write(2'b10, 4'b1111, 32'h0);
    check("off_pwrdn", 32'(pwrdn), 32'(1));
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("off_hold%0d", k), 32'({dclk, dac_data}), 32'({1'b0, 10'h3FF}));
    end

    // Format bit with conversion
    do_reset(2);
    bus_write(2'b01, 4'b1111, 32'h03C0_0000);
    bus_write(2'b10, 4'b1111, 32'hC000_0000);
    check("fmt_format", 32'(fmt_o), 32'(exp_format(1'b1)));
    wait_fall(seen);
    check("fmt_fall_seen", 32'(seen), 32'(1));
`ifdef DAC_FORMAT_CONV_EN
    check("fmt_dac", 32'(dac_data), 32'(10'h20F));
`else
    check("fmt_dac", 32'(dac_data), 32'(10'h00F));
`endif

    // DIV=3: first rise after DIV+1 clocks, period 8
    do_reset(2);
    bus_write(2'b10, 4'b1111, 32'h8000_0003);
    rdce = 2'b10;
    #1;
    check("div3_rdack", 32'(rdack), 32'(1));
    check("div3_rdata", 32'(ip2bus_data), 32'h8000_0003);
    rdce = 2'b00;
    count_until(1'b1, n_rise);
    check("div3_first_rise", 32'(n_rise), 32'(4));
    count_until(1'b0, n_hi);
    count_until(1'b1, n_lo);
    check("div3_high", 32'(n_hi), 32'(4));
    check("div3_period", 32'(n_hi + n_lo), 32'(8));

    // Reset mid-operation (DCLKIO currently high)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_dclk",  32'({dclk, clkout}), 32'(0));
    check("midrst_pwrdn", 32'(pwrdn), 32'(1));
    check("midrst_dac",   32'(dac_data), 32'(0));
    rdce = 2'b10;
    #1;
    check("midrst_ctrl", 32'(ip2bus_data), 32'(0));
    rdce = 2'b00;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
